// File: rtl/afu_write_drain.sv
// rtl/afu_write_drain.sv - drains AFU output FIFO lines into addressed host write requests
module afu_write_drain #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           ctx_length,
    input  logic [ADDR_WIDTH-1:0] dst_base_addr,
    input  logic [511:0]          fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_re,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [511:0]          wr_data,
    input  logic                  wr_ack,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  len;
    logic [CNT_WIDTH-1:0]  rd_issued;
    logic [CNT_WIDTH-1:0]  wr_sent;
    logic [CNT_WIDTH-1:0]  ack_cnt;
    logic [ADDR_WIDTH-1:0] base;

    logic [511:0]          buf_mem [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            occ;
    logic                  inflight;

    logic                  push;
    logic                  pop;
    logic [2:0]            occ_proj;
    logic                  ack_last;

    assign pop      = wr_valid & wr_ready;
    assign push     = inflight;
    assign wr_valid = (occ != 2'd0);
    assign wr_data  = buf_mem[head];
    assign wr_addr  = base + ADDR_WIDTH'(wr_sent);

    // Projected occupancy counts the line already requested but not yet landed,
    // so a read is only issued when a buffer slot is guaranteed for it.
    assign occ_proj = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_re  = (state == S_RUN) & ~fifo_empty & (rd_issued < len) & (occ_proj < 3'd2);

    assign ack_last = wr_ack & (ack_cnt + CNT_WIDTH'(1) == len);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            len        <= '0;
            rd_issued  <= '0;
            wr_sent    <= '0;
            ack_cnt    <= '0;
            base       <= '0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            head       <= 1'b0;
            tail       <= 1'b0;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            inflight <= fifo_re;

            if (fifo_re) begin
                rd_issued <= rd_issued + CNT_WIDTH'(1);
            end
            if (pop) begin
                wr_sent <= wr_sent + CNT_WIDTH'(1);
                head    <= ~head;
            end
            if (push) begin
                buf_mem[tail] <= fifo_dout;
                tail          <= ~tail;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase

            if (busy && wr_ack && (ack_cnt < len)) begin
                ack_cnt <= ack_cnt + CNT_WIDTH'(1);
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len       <= CNT_WIDTH'(ctx_length);
                        base      <= dst_base_addr;
                        rd_issued <= '0;
                        wr_sent   <= '0;
                        ack_cnt   <= '0;
                        if (ctx_length == 32'd0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (wr_sent == len) begin
                        state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    // Completing on the final ack itself lets done rise the very next cycle.
                    if ((ack_cnt == len) || ack_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (occ == 2'd2)));

endmodule

// File: tb/tb_afu_write_drain.sv
// tb/tb_afu_write_drain.sv - scoreboard bench for afu_write_drain with a queue-based source and ack model
module tb_afu_write_drain;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  ctx_length;
    logic [31:0]  dst_base_addr;
    logic [511:0] fifo_dout = '0;
    logic         fifo_empty = 1'b1;
    logic         fifo_re;
    logic         wr_valid;
    logic         wr_ready = 1'b1;
    logic [31:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_ack = 1'b0;
    logic         busy;
    logic         done;

    afu_write_drain #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ctx_length(ctx_length),
        .dst_base_addr(dst_base_addr), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_re(fifo_re), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] data;
    } wr_t;

    wr_t          exp_q[$];
    logic [511:0] src[$];
    int           ack_due[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit starve = 0;
    int ready_mode = 0;
    int ack_min = 2;
    int ack_span = 0;
    int jb_len = 0;
    bit jb_active = 0;
    int tb_acks = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int done_due = -1;
    int first_wr = -1;
    int last_wr = -1;
    int last_ack = 0;
    logic [31:0]  last_addr = '0;
    bit           stall_prev = 0;
    logic [31:0]  stall_addr = '0;
    logic [511:0] stall_data = '0;
    bit           starve_gap = 0;

    task automatic chk(input bit ok, input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Upstream FIFO: data appears the cycle after a read enable
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_re && src.size() > 0) fifo_dout <= src.pop_front();
    end

    always @(negedge clk) begin
        fifo_empty = starve || (src.size() == 0);
        case (ready_mode)
            1:       wr_ready = (cyc % 3 == 0);
            2:       wr_ready = (($urandom % 4) != 0);
            default: wr_ready = 1'b1;
        endcase
        if (ack_due.size() > 0 && ack_due[0] <= cyc) begin
            wr_ack = 1'b1;
            void'(ack_due.pop_front());
        end else begin
            wr_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        wr_t e;
        int  d;
        #1;
        if (!reset) begin
            chk(!(busy && done), "busy_done_exclusive", {busy, done}, 2'b00);
            if (fifo_re) begin
                rd_cnt++;
                chk(!fifo_empty, "read_when_empty", fifo_empty, 0);
                chk(rd_cnt <= jb_len, "read_beyond_len", rd_cnt, jb_len);
            end
            if (stall_prev) begin
                chk(wr_valid, "stall_valid_hold", wr_valid, 1);
                chk(wr_addr == stall_addr, "stall_addr_hold", wr_addr, stall_addr);
                chk(wr_data == stall_data, "stall_data_hold", wr_data, stall_data);
            end
            if (starve && !wr_valid) starve_gap = 1;
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_write", wr_addr, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(wr_addr == e.addr, "write_addr", wr_addr, e.addr);
                    chk(wr_data == e.data, "write_data", wr_data, e.data);
                end
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                last_addr = wr_addr;
                d = cyc + ack_min + int'($urandom_range(0, ack_span));
                if (d <= last_ack) d = last_ack + 1;
                last_ack = d;
                ack_due.push_back(d);
            end
            stall_prev = wr_valid && !wr_ready;
            stall_addr = wr_addr;
            stall_data = wr_data;
            if (wr_ack && jb_active) begin
                tb_acks++;
                if (tb_acks == jb_len) done_due = cyc + 1;
            end
            if (cyc == done_due) begin
                chk(done, "done_timing", done, 1);
                jb_active = 0;
                done_due = -1;
            end
        end
    end

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic load_job(input int len, input logic [31:0] base, input int extra);
        logic [511:0] line;
        for (int k = 0; k < len; k++) begin
            line = rand_line();
            src.push_back(line);
            exp_q.push_back('{base + 32'(k), line});
        end
        for (int k = 0; k < extra; k++) src.push_back(rand_line());
    endtask

    task automatic fire_start(input int len, input logic [31:0] base, output int sc);
        @(negedge clk);
        jb_len = len;
        tb_acks = 0;
        wr_cnt = 0;
        rd_cnt = 0;
        first_wr = -1;
        last_ack = 0;
        jb_active = 1;
        start = 1'b1;
        ctx_length = len;
        dst_base_addr = base;
        sc = cyc;
        if (len == 0) done_due = sc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (jb_active && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (jb_active) begin
            chk(0, "job_timeout", n, budget);
            jb_active = 0;
        end
        @(negedge clk);
        chk(rd_cnt == jb_len, "job_read_count", rd_cnt, jb_len);
        chk(wr_cnt == jb_len, "job_write_count", wr_cnt, jb_len);
        chk(exp_q.size() == 0, "job_lines_left", exp_q.size(), 0);
        src.delete();
        exp_q.delete();
    endtask

    task automatic wait_writes(input int n);
        int k = 0;
        while (wr_cnt < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(wr_cnt >= n, "write_progress", wr_cnt, n);
    endtask

    task automatic check_zero(input string tag);
        chk(!fifo_re, {tag, "_fifo_re"}, fifo_re, 0);
        chk(!wr_valid, {tag, "_wr_valid"}, wr_valid, 0);
        chk(!busy, {tag, "_busy"}, busy, 0);
        chk(!done, {tag, "_done"}, done, 0);
        chk(wr_addr == 32'd0, {tag, "_wr_addr"}, wr_addr, 0);
        chk(wr_data == '0, {tag, "_wr_data"}, wr_data, 0);
    endtask

    initial begin
        int sc;
        reset = 1'b1;
        start = 1'b0;
        ctx_length = '0;
        dst_base_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // zero-length job straight from IDLE, with data available that must not be read
        load_job(0, 32'h0, 3);
        fire_start(0, 32'h40, sc);
        wait_done(20);

        // basic stream: exact write cycles
        load_job(4, 32'h100, 0);
        fire_start(4, 32'h100, sc);
        wait_done(200);
        chk(first_wr == sc + 3, "basic_first_write_cycle", first_wr - sc, 3);
        chk(last_wr == sc + 6, "basic_last_write_cycle", last_wr - sc, 6);

        // backpressure with surplus upstream data
        ready_mode = 1;
        load_job(8, 32'h2000, 3);
        fire_start(8, 32'h2000, sc);
        wait_done(400);
        ready_mode = 0;

        // starved source mid-job
        load_job(8, 32'h3000, 0);
        fire_start(8, 32'h3000, sc);
        wait_writes(2);
        starve_gap = 0;
        starve = 1;
        repeat (5) @(negedge clk);
        starve = 0;
        chk(starve_gap, "starve_valid_dropped", starve_gap, 1);
        wait_done(400);

        // start during RUN is ignored
        load_job(3, 32'h4000, 2);
        fire_start(3, 32'h4000, sc);
        @(negedge clk);
        start = 1'b1;
        ctx_length = 7;
        dst_base_addr = 32'h9999;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);

        // address wrap-around
        load_job(4, 32'hFFFF_FFFE, 0);
        fire_start(4, 32'hFFFF_FFFE, sc);
        wait_done(200);
        chk(last_addr == 32'h1, "wrap_last_addr", last_addr, 1);

        // reset mid-job, then a clean short job
        load_job(6, 32'h5000, 0);
        fire_start(6, 32'h5000, sc);
        wait_writes(2);
        reset = 1'b1;
        exp_q.delete();
        src.delete();
        ack_due.delete();
        jb_active = 0;
        done_due = -1;
        stall_prev = 0;
        @(negedge clk);
        #1;
        check_zero("midjob_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_job(2, 32'h6000, 1);
        fire_start(2, 32'h6000, sc);
        wait_done(200);
        chk(first_wr == sc + 3, "post_reset_first_write", first_wr - sc, 3);

        // randomized jobs
        ready_mode = 2;
        ack_span = 3;
        for (int j = 0; j < 5; j++) begin
            int len;
            logic [31:0] base;
            len = int'($urandom_range(1, 12));
            base = $urandom;
            load_job(len, base, int'($urandom_range(0, 3)));
            fire_start(len, base, sc);
            wait_done(800);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
